// File: rtl/ovrd_pkg.sv
// rtl/ovrd_pkg.sv - shared constants and sample type for the overdrive output level stage
package ovrd_pkg;

    localparam int FXP_SIZE          = 16;
    localparam int BITS_PER_VOL_FRAC = 8;
    localparam int RAMP_STEP         = 16;
    localparam int CLIP_CNT_W        = 16;

    typedef logic signed [FXP_SIZE-1:0] sample_t;

endpackage

// File: rtl/ovrd_sat.sv
// rtl/ovrd_sat.sv - combinational two's complement saturation from in_w to out_w bits
module ovrd_sat #(
    parameter int in_w  = 49,
    parameter int out_w = 16
) (
    input  logic [in_w-1:0]  din,
    output logic [out_w-1:0] dout,
    output logic             clip
);

    logic [in_w-out_w:0] hi;

    // value fits when every bit from the output sign bit upward is a copy of the sign
    always_comb begin
        hi   = din[in_w-1:out_w-1];
        clip = !((hi == '0) || (hi == '1));
        if (clip) begin
            dout = din[in_w-1] ? {1'b1, {(out_w-1){1'b0}}} : {1'b0, {(out_w-1){1'b1}}};
        end else begin
            dout = din[out_w-1:0];
        end
    end

endmodule

// File: rtl/ovrd_level_out.sv
// rtl/ovrd_level_out.sv - ramped master volume and saturation, two-stage pipeline; OVRD_LEVEL_OUT_CLIP_CNT_EN adds o_clip_cnt
module ovrd_level_out
    import ovrd_pkg::*;
#(
    parameter int fxp_size          = FXP_SIZE,
    parameter int bits_per_vol_frac = BITS_PER_VOL_FRAC,
    parameter int ramp_step         = RAMP_STEP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*fxp_size-1:0]   i_sample,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [fxp_size-1:0]     i_volume,
    output logic [fxp_size-1:0]     o_sample,
    output logic                    o_valid,
    input  logic                    i_ready
`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
    ,
    output logic [CLIP_CNT_W-1:0]   o_clip_cnt
`endif
);

    localparam int PW = 3*fxp_size + 1;
    localparam logic [fxp_size:0] STEP = (fxp_size+1)'(ramp_step);

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_load;
    logic                 s2_load;
    logic                 in_xfer;
    logic signed [PW-1:0] s1_prod;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] shifted;
    logic [fxp_size-1:0]  sat_out;
    logic                 sat_clip;
    logic [fxp_size-1:0]  cur_vol;
    logic [fxp_size-1:0]  next_vol;
    logic [fxp_size:0]    diff;

    assign o_valid = s2_valid;

    // pipeline advance: a stage loads when empty or when its contents move on
    always_comb begin
        s2_load = !s2_valid || i_ready;
        s1_load = !s1_valid || s2_load;
        o_ready = rst && s1_load;
        in_xfer = i_valid && o_ready;
    end

    // signed sample times unsigned volume, widened so the product never overflows
    always_comb begin
        prod_c = PW'($signed(i_sample)) * PW'($signed({1'b0, cur_vol}));
    end

    // ramp toward the target one bounded step, computed one bit wider so it cannot wrap
    always_comb begin
        next_vol = cur_vol;
        diff     = '0;
        if (cur_vol < i_volume) begin
            diff     = {1'b0, i_volume} - {1'b0, cur_vol};
            next_vol = (diff > STEP) ? fxp_size'({1'b0, cur_vol} + STEP) : i_volume;
        end else if (cur_vol > i_volume) begin
            diff     = {1'b0, cur_vol} - {1'b0, i_volume};
            next_vol = (diff > STEP) ? fxp_size'({1'b0, cur_vol} - STEP) : i_volume;
        end
    end

    // arithmetic shift floors toward minus infinity
    assign shifted = s1_prod >>> bits_per_vol_frac;

    ovrd_sat #(
        .in_w  (PW),
        .out_w (fxp_size)
    ) u_sat (
        .din  (shifted),
        .dout (sat_out),
        .clip (sat_clip)
    );

    // S1 product, S2 saturated output, and the applied volume (pre-update value scales the sample)
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_prod  <= '0;
            o_sample <= '0;
            cur_vol  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_xfer;
                if (in_xfer) begin
                    s1_prod <= prod_c;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    o_sample <= sat_out;
                end
            end
            if (in_xfer) begin
                cur_vol <= next_vol;
            end
        end
    end

`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
    logic                  out_xfer;
    logic                  s2_clip;
    logic [CLIP_CNT_W-1:0] clip_cnt;

    assign out_xfer   = s2_valid && i_ready;
    assign o_clip_cnt = clip_cnt;

    // clip flag travels with the S2 sample; counted once when that sample leaves
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_clip  <= 1'b0;
            clip_cnt <= '0;
        end else begin
            if (s2_load && s1_valid) begin
                s2_clip <= sat_clip;
            end
            if (out_xfer && s2_clip && (clip_cnt != '1)) begin
                clip_cnt <= clip_cnt + 1'b1;
            end
        end
    end
`else
    logic clip_unused;
    assign clip_unused = sat_clip;
`endif

endmodule

// File: tb/tb_ovrd_level_out.sv
// tb/tb_ovrd_level_out.sv - self-checking bench for ovrd_level_out
module tb_ovrd_level_out;
    import ovrd_pkg::*;

    localparam int F    = FXP_SIZE;
    localparam int FR   = BITS_PER_VOL_FRAC;
    localparam int STEP = RAMP_STEP;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*F-1:0] i_sample;
    logic           i_valid;
    logic           o_ready;
    logic [F-1:0]   i_volume;
    logic [F-1:0]   o_sample;
    logic           o_valid;
    logic           i_ready;
`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
    logic [CLIP_CNT_W-1:0] o_clip_cnt;
`endif

    ovrd_level_out #(
        .fxp_size          (F),
        .bits_per_vol_frac (FR),
        .ramp_step         (STEP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_sample (i_sample),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_volume (i_volume),
        .o_sample (o_sample),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
        ,
        .o_clip_cnt (o_clip_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_vol  = 0;
    int n_in   = 0;
    int n_out  = 0;
    int m_clips = 0;
    int exp_q[$];
    int obs_q[$];
    bit clip_q[$];

    function automatic int ref_scale(input longint s, input longint v, output bit clipped);
        longint p, q, div, hi, lo;
        div = longint'(1) << FR;
        hi  = (longint'(1) << (F-1)) - 1;
        lo  = -(longint'(1) << (F-1));
        p   = s * v;
        q   = p / div;
        if (p < 0 && (p % div) != 0) q = q - 1;
        clipped = (q > hi) || (q < lo);
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic int ref_ramp(input int cur, input int tgt);
        if (cur < tgt) return (cur + STEP < tgt) ? cur + STEP : tgt;
        if (cur > tgt) return (cur - STEP > tgt) ? cur - STEP : tgt;
        return cur;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        obs_q.delete();
        clip_q.delete();
        m_vol   = 0;
        n_in    = 0;
        n_out   = 0;
        m_clips = 0;
    endtask

    // called at a falling edge with inputs already driven; records transfers then advances one cycle
    task automatic cycle();
        sample_t s;
        bit      c;
        #1;
        if (o_valid && i_ready) begin
            s = o_sample;
            obs_q.push_back(int'(s));
            n_out++;
            if (clip_q.size() > 0) begin
                if (clip_q.pop_front()) m_clips++;
            end
        end
        if (i_valid && o_ready) begin
            exp_q.push_back(ref_scale(longint'($signed(i_sample)), longint'(m_vol), c));
            clip_q.push_back(c);
            m_vol = ref_ramp(m_vol, int'(i_volume));
            n_in++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_sample = '0; i_volume = '0;
        repeat (2) @(negedge clk);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_o_ready got %0b expected 0", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %0b expected 0", o_valid); end
        checks++; if (o_sample !== '0) begin errors++; $display("FAIL reset_o_sample got %0d expected 0", o_sample); end
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL release_o_ready got %0b expected 1", o_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL release_o_valid got %0b expected 0", o_valid); end
    endtask

    task automatic test_ramp();
        int e;
        obs_q.delete(); exp_q.delete();
        for (int n = 0; n < 20; n++) begin
            i_valid = 1'b1; i_sample = 1000; i_volume = 256; i_ready = 1'b1;
            checks++;
            if (o_valid !== 1'(n >= 2)) begin errors++; $display("FAIL ramp_latency cycle %0d got %0b expected %0b", n, o_valid, (n >= 2)); end
            cycle();
        end
        drain();
        checks++; if (obs_q.size() != 20) begin errors++; $display("FAIL ramp_count got %0d expected 20", obs_q.size()); end
        for (int k = 0; k < 20 && k < obs_q.size(); k++) begin
            e = (1000 * ((16*k < 256) ? 16*k : 256)) / 256;
            checks++;
            if (obs_q[k] !== e) begin errors++; $display("FAIL ramp_out[%0d] got %0d expected %0d", k, obs_q[k], e); end
        end
    endtask

    task automatic test_half_vol();
        int vals[4] = '{1001, -1001, 40000, -40000};
        int want[4] = '{500, -501, 32767, -32768};
        int idx[4]  = '{10, 11, 22, 23};
        obs_q.delete(); exp_q.delete();
        i_ready = 1'b1; i_valid = 1'b1; i_volume = 128;
        for (int n = 0; n < 10; n++) begin i_sample = 0; cycle(); end
        for (int n = 0; n < 2; n++) begin i_sample = vals[n]; cycle(); end
        i_volume = 256;
        for (int n = 0; n < 10; n++) begin i_sample = 0; cycle(); end
        for (int n = 2; n < 4; n++) begin i_sample = vals[n]; cycle(); end
        drain();
        checks++; if (obs_q.size() != 24) begin errors++; $display("FAIL half_count got %0d expected 24", obs_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q.size() <= idx[k] || obs_q[idx[k]] !== want[k]) begin
                errors++;
                $display("FAIL half_out[%0d] got %0d expected %0d", k, (obs_q.size() > idx[k]) ? obs_q[idx[k]] : -99999, want[k]);
            end
        end
`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
        checks++; if (o_clip_cnt !== 16'd2) begin errors++; $display("FAIL clip_cnt got %0d expected 2", o_clip_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        int vals[4] = '{11, 22, 33, 44};
        int acc = 0;
        bit took;
        obs_q.delete(); exp_q.delete();
        i_volume = 256; i_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_valid = 1'b1; i_sample = vals[acc];
            #1;
            checks++; if (o_ready !== 1'(acc < 2)) begin errors++; $display("FAIL bp_ready cycle %0d got %0b expected %0b", c, o_ready, (acc < 2)); end
            if (c >= 2) begin
                checks++;
                if (o_valid !== 1'b1 || o_sample !== 16'd11) begin
                    errors++; $display("FAIL bp_hold cycle %0d got valid %0b sample %0d expected valid 1 sample 11", c, o_valid, o_sample);
                end
            end
            took = o_ready;
            cycle();
            if (took) acc++;
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted got %0d expected 2", acc); end
        i_ready = 1'b1;
        for (int c = 0; c < 10 && acc < 4; c++) begin
            i_valid = 1'b1; i_sample = vals[acc];
            #1; took = o_ready;
            cycle();
            if (took) acc++;
        end
        drain();
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d expected 4", obs_q.size()); end
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== vals[k]) begin errors++; $display("FAIL bp_order[%0d] got %0d expected %0d", k, obs_q[k], vals[k]); end
        end
    endtask

    task automatic test_redirect();
        int want[8] = '{128, 144, 160, 144, 128, 112, 100, 100};
        i_ready = 1'b1; i_valid = 1'b1; i_volume = 128;
        for (int n = 0; n < 10; n++) begin i_sample = 0; cycle(); end
        drain();
        obs_q.delete(); exp_q.delete();
        for (int t = 0; t < 8; t++) begin
            i_valid = 1'b1; i_sample = 256;
            i_volume = (t < 2) ? 16'd256 : 16'd100;
            cycle();
        end
        drain();
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL redirect_count got %0d expected 8", obs_q.size()); end
        for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== want[k]) begin errors++; $display("FAIL redirect_vol[%0d] got %0d expected %0d", k, obs_q[k], want[k]); end
        end
    endtask

    task automatic test_random();
        bit exp_ready;
        obs_q.delete(); exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) i_sample = $urandom();
            else i_sample = int'($urandom_range(0, 2000)) - 1000;
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 1) i_volume = 16'($urandom());
                else i_volume = 16'($urandom_range(0, 400));
            end
            #1;
            exp_ready = ((n_in - n_out) < 2) || i_ready;
            checks++; if (o_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cycle %0d got %0b expected %0b", c, o_ready, exp_ready); end
            cycle();
        end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_out[%0d] got %0d expected %0d", k, obs_q[k], exp_q[k]); end
        end
`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
        checks++; if (o_clip_cnt !== 16'(m_clips)) begin errors++; $display("FAIL rand_clip_cnt got %0d expected %0d", o_clip_cnt, m_clips); end
`endif
    endtask

    task automatic test_reset_mid();
        i_volume = 256; i_ready = 1'b0; i_valid = 1'b1;
        i_sample = 300; cycle();
        i_sample = 400; cycle();
        rst = 1'b0; i_sample = 777;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %0b expected 0", o_ready); end
        cycle();
        rst = 1'b1; i_valid = 1'b0;
        model_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid got %0b expected 0", o_valid); end
        checks++; if (o_sample !== '0) begin errors++; $display("FAIL midrst_o_sample got %0d expected 0", o_sample); end
`ifdef OVRD_LEVEL_OUT_CLIP_CNT_EN
        checks++; if (o_clip_cnt !== '0) begin errors++; $display("FAIL midrst_clip_cnt got %0d expected 0", o_clip_cnt); end
`endif
        i_valid = 1'b1; i_sample = 5000; i_ready = 1'b1;
        cycle();
        i_valid = 1'b0;
        for (int c = 0; c < 6 && obs_q.size() == 0; c++) cycle();
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL midrst_timeout got %0d outputs expected 1", obs_q.size()); end
        else if (obs_q[0] !== 0) begin errors++; $display("FAIL midrst_first got %0d expected 0", obs_q[0]); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_half_vol();
        test_backpressure();
        test_redirect();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
